// File: rtl/mux_key_with_default.sv
// Key-lookup multiplexer over a packed (key, data) pair table, with a default value on miss.
// Provides a combinational result and a registered copy with one cycle of latency.
module mux_key_with_default #(
    parameter int unsigned NR_KEY   = 2,
    parameter int unsigned KEY_LEN  = 1,
    parameter int unsigned DATA_LEN = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [DATA_LEN-1:0]                  default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    input  logic                                 en,
    output logic [DATA_LEN-1:0]                  out,
    output logic                                 hit,
    output logic [DATA_LEN-1:0]                  out_q,
    output logic                                 hit_q
);

    localparam int unsigned PAIR = KEY_LEN + DATA_LEN;

    logic [DATA_LEN-1:0] w_out;
    logic                w_hit;
    logic [DATA_LEN-1:0] r_out_q;
    logic                r_hit_q;

    // Descending scan: the lowest-index matching pair is written last and wins.
    always_comb begin
        w_out = default_out;
        w_hit = 1'b0;
        for (int unsigned i = NR_KEY; i > 0; i--) begin
            if (lut[PAIR*(i-1) + DATA_LEN +: KEY_LEN] == key) begin
                w_out = lut[PAIR*(i-1) +: DATA_LEN];
                w_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_q <= '0;
            r_hit_q <= 1'b0;
        end else if (en) begin
            r_out_q <= w_out;
            r_hit_q <= w_hit;
        end
    end

    assign out   = w_out;
    assign hit   = w_hit;
    assign out_q = r_out_q;
    assign hit_q = r_hit_q;

endmodule

// File: tb/tb_mux_key_with_default.sv
// Self-checking bench for mux_key_with_default: directed table cases, registered path,
// asynchronous reset, and randomized lookups against a first-match reference model.
module tb_mux_key_with_default;

    logic clk;
    logic rst;
    logic en;
    logic en_c;

    // Instance A: NR_KEY=1, KEY_LEN=7, DATA_LEN=3
    logic [6:0] key_a;
    logic [2:0] def_a;
    logic [9:0] lut_a;
    logic [2:0] out_a;
    logic       hit_a;
    logic [2:0] outq_a;
    logic       hitq_a;

    // Instance B: NR_KEY=3, KEY_LEN=2, DATA_LEN=4
    logic [1:0]  key_b;
    logic [3:0]  def_b;
    logic [17:0] lut_b;
    logic [3:0]  out_b;
    logic        hit_b;
    logic [3:0]  outq_b;
    logic        hitq_b;

    // Instance C: NR_KEY=4, KEY_LEN=3, DATA_LEN=5 (randomized)
    logic [2:0]  key_c;
    logic [4:0]  def_c;
    logic [31:0] lut_c;
    logic [4:0]  out_c;
    logic        hit_c;
    logic [4:0]  outq_c;
    logic        hitq_c;

    logic [2:0] rk [4];
    logic [4:0] rd [4];

    int n_pass  = 0;
    int n_total = 0;

    mux_key_with_default #(.NR_KEY(1), .KEY_LEN(7), .DATA_LEN(3)) u_a (
        .clk(clk), .rst(rst), .key(key_a), .default_out(def_a), .lut(lut_a), .en(en),
        .out(out_a), .hit(hit_a), .out_q(outq_a), .hit_q(hitq_a)
    );

    mux_key_with_default #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(4)) u_b (
        .clk(clk), .rst(rst), .key(key_b), .default_out(def_b), .lut(lut_b), .en(en),
        .out(out_b), .hit(hit_b), .out_q(outq_b), .hit_q(hitq_b)
    );

    mux_key_with_default #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(5)) u_c (
        .clk(clk), .rst(rst), .key(key_c), .default_out(def_c), .lut(lut_c), .en(en_c),
        .out(out_c), .hit(hit_c), .out_q(outq_c), .hit_q(hitq_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: first pair (ascending index) whose key equals k supplies the data.
    function automatic void model(input logic [2:0] k, output logic [4:0] d, output logic h);
        int idx[$];
        idx = rk.find_first_index with (item == k);
        if (idx.size() == 0) begin
            d = def_c;
            h = 1'b0;
        end else begin
            d = rd[idx[0]];
            h = 1'b1;
        end
    endfunction

    initial begin
        logic [4:0] exp_d;
        logic       exp_h;
        logic [4:0] exp_q;
        logic       exp_hq;

        rst   = 1'b1;
        en    = 1'b0;
        en_c  = 1'b0;
        key_a = '0;
        key_b = '0;
        key_c = '0;
        def_a = 3'b111;
        def_b = 4'hF;
        def_c = '0;
        lut_a = {7'b0010011, 3'b000};
        lut_b = {2'b10, 4'h3, 2'b01, 4'h2, 2'b00, 4'h1};
        lut_c = '0;
        #2;
        chk("rst_outq_b", 32'(outq_b), 32'h0);
        chk("rst_hitq_b", 32'(hitq_b), 32'h0);
        chk("rst_outq_c", 32'(outq_c), 32'h0);

        key_a = 7'b0010011; #1;
        chk("a_hit_out", 32'(out_a), 32'h0);
        chk("a_hit_hit", 32'(hit_a), 32'h1);
        key_a = 7'b0110111; #1;
        chk("a_miss_out", 32'(out_a), 32'h7);
        chk("a_miss_hit", 32'(hit_a), 32'h0);

        for (int k = 0; k < 3; k++) begin
            key_b = 2'(k); #1;
            chk("b_key_out", 32'(out_b), 32'(k + 1));
            chk("b_key_hit", 32'(hit_b), 32'h1);
        end
        key_b = 2'b11; #1;
        chk("b_miss_out", 32'(out_b), 32'hF);
        chk("b_miss_hit", 32'(hit_b), 32'h0);

        lut_b = {2'b01, 4'h5, 2'b10, 4'h3, 2'b01, 4'hA};
        key_b = 2'b01; #1;
        chk("b_dup_out", 32'(out_b), 32'hA);
        chk("b_dup_hit", 32'(hit_b), 32'h1);
        lut_b = {2'b10, 4'h3, 2'b01, 4'h2, 2'b00, 4'h1};

        // Registered path
        @(negedge clk);
        rst = 1'b0; en = 1'b1; key_b = 2'b01;
        @(posedge clk); #1;
        chk("q_first_out", 32'(outq_b), 32'h2);
        chk("q_first_hit", 32'(hitq_b), 32'h1);
        @(negedge clk);
        key_b = 2'b11; #1;
        chk("q_pre_edge", 32'(outq_b), 32'h2);
        @(posedge clk); #1;
        chk("q_new_out", 32'(outq_b), 32'hF);
        chk("q_new_hit", 32'(hitq_b), 32'h0);

        @(negedge clk);
        en = 1'b0; key_b = 2'b00;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            chk("hold_out", 32'(outq_b), 32'hF);
            chk("hold_hit", 32'(hitq_b), 32'h0);
            @(negedge clk);
            key_b = key_b + 2'd1;
        end

        // Asynchronous reset between edges
        en = 1'b1; key_b = 2'b10;
        @(posedge clk); #1;
        chk("pre_rst_q", 32'(outq_b), 32'h3);
        @(negedge clk); #2;
        rst = 1'b1; #1;
        chk("async_rst_outq", 32'(outq_b), 32'h0);
        chk("async_rst_hitq", 32'(hitq_b), 32'h0);
        chk("async_rst_out", 32'(out_b), 32'h3);
        @(posedge clk); #1;
        chk("rst_held_outq", 32'(outq_b), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_outq", 32'(outq_b), 32'h3);
        chk("post_rst_hitq", 32'(hitq_b), 32'h1);

        // Randomized lookups and registered capture on instance C
        exp_q  = '0;
        exp_hq = 1'b0;
        for (int it = 0; it < 150; it++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                rk[i] = 3'($urandom_range(0, 7));
                rd[i] = 5'($urandom);
                lut_c[i*8 +: 8] = {rk[i], rd[i]};
            end
            key_c = 3'($urandom_range(0, 7));
            def_c = 5'($urandom);
            en_c  = 1'($urandom);
            #1;
            model(key_c, exp_d, exp_h);
            chk("rnd_out", 32'(out_c), 32'(exp_d));
            chk("rnd_hit", 32'(hit_c), 32'(exp_h));
            if (en_c) begin
                exp_q  = exp_d;
                exp_hq = exp_h;
            end
            @(posedge clk); #1;
            chk("rnd_outq", 32'(outq_c), 32'(exp_q));
            chk("rnd_hitq", 32'(hitq_c), 32'(exp_hq));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
